fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit CPU: owns the 15-bit program counter register, reads one 8-bit instruction per step from program memory over a req/ack handshake, and presents it to the decode/execute stage with a valid/ready handshake. The next-PC logic sits immediately downstream: it takes `PC` plus the decoded jump/page fields and returns `PC_next`, which this block loads when the current instruction is consumed. The block also provides halt and a bus-timeout error.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory-read bus, decode hand-off and next-PC inputs.
// Both handshakes are level-based and complete on a rising edge. MEM_REQ/MEM_ADDR hold
// until an edge where MEM_ACK=1 (MEM_DATA is valid in that cycle). INSTR/INSTR_VALID/PC
// hold until an edge where INSTR_READY=1.
interface fetch_unit_if;
  logic [14:0] PC_next;
  logic        HALT;
  logic        MEM_REQ;
  logic [14:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [7:0]  MEM_DATA;
  logic [7:0]  INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [14:0] PC;
  logic        FETCH_ERR;

  modport master (
    input  PC_next, HALT, MEM_ACK, MEM_DATA, INSTR_READY,
    output MEM_REQ, MEM_ADDR, INSTR, INSTR_VALID, PC, FETCH_ERR
  );

  modport slave (
    output PC_next, HALT, MEM_ACK, MEM_DATA, INSTR_READY,
    input  MEM_REQ, MEM_ADDR, INSTR, INSTR_VALID, PC, FETCH_ERR
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one byte per step from program memory
// and hands it to decode. A fetch that goes unacknowledged too long latches a sticky error.
module fetch_unit #(
  parameter logic [14:0] RESET_PC = 15'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic         CLK,
  input  logic         RESET_N,
  fetch_unit_if.master bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [7:0]  instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.HALT) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      S_FETCH: begin
        // An ack in the same cycle as the final wait beats the timeout.
        if (bus.MEM_ACK) begin
          instr_d = bus.MEM_DATA;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_VALID: begin
        if (bus.INSTR_READY) begin
          pc_d    = bus.PC_next;
          valid_d = 1'b0;
          if (bus.HALT) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
          end
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.MEM_REQ     = req_q;
  assign bus.MEM_ADDR    = pc_q;
  assign bus.PC          = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.FETCH_ERR   = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a flag-based reference of the fetch stage is compared
// every cycle, and literal expectations pin key points of each scenario.
module tb_fetch_unit;

  localparam int unsigned TMO = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;
  bit         model_live;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (15'h0000),
    .TIMEOUT  (TMO)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks only what is observable: request outstanding, instruction held, dead.
  logic        m_req;
  logic [14:0] m_pc;
  logic [7:0]  m_instr;
  logic        m_valid;
  logic        m_err;
  int          m_wait;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_req = 1'b0; m_pc = 15'h0000; m_instr = 8'h00;
      m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
    end else if (m_err) begin
      // dead until reset
    end else if (m_valid) begin
      if (bus.INSTR_READY) begin
        m_pc = bus.PC_next;
        m_valid = 1'b0;
        m_req = !bus.HALT;
        m_wait = 0;
      end
    end else if (m_req) begin
      if (bus.MEM_ACK) begin
        m_instr = bus.MEM_DATA;
        m_valid = 1'b1;
        m_req = 1'b0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == int'(TMO)) begin
          m_req = 1'b0;
          m_err = 1'b1;
        end
      end
    end else if (!bus.HALT) begin
      m_req = 1'b1;
      m_wait = 0;
    end
    model_live = 1'b1;
  end

  always begin
    @(posedge clk);
    #1;
    if (model_live) begin
      chk("cyc_mem_req",   32'(bus.MEM_REQ),     32'(m_req));
      chk("cyc_mem_addr",  32'(bus.MEM_ADDR),    32'(m_pc));
      chk("cyc_pc",        32'(bus.PC),          32'(m_pc));
      chk("cyc_instr",     32'(bus.INSTR),       32'(m_instr));
      chk("cyc_valid",     32'(bus.INSTR_VALID), 32'(m_valid));
      chk("cyc_fetch_err", 32'(bus.FETCH_ERR),   32'(m_err));
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_mem(input logic ack, input logic [7:0] data);
    bus.MEM_ACK  = ack;
    bus.MEM_DATA = data;
  endtask

  task automatic set_dec(input logic ready, input logic [14:0] nxt);
    bus.INSTR_READY = ready;
    bus.PC_next     = nxt;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    tests = 0; fails = 0; model_live = 1'b0;
    rst_n = 1'b0;
    bus.HALT = 1'b0;
    set_mem(1'b0, 8'h00);
    set_dec(1'b0, 15'h0000);

    // Reset values, then zero-wait fetch of 8'hA5 at address 0
    step(2);
    chk("rst_req",   32'(bus.MEM_REQ),     32'd0);
    chk("rst_pc",    32'(bus.PC),          32'd0);
    chk("rst_instr", 32'(bus.INSTR),       32'd0);
    chk("rst_valid", 32'(bus.INSTR_VALID), 32'd0);
    chk("rst_err",   32'(bus.FETCH_ERR),   32'd0);
    rst_n = 1'b1;
    step(1);
    chk("first_req",  32'(bus.MEM_REQ),  32'd1);
    chk("first_addr", 32'(bus.MEM_ADDR), 32'd0);
    set_mem(1'b1, 8'hA5);
    step(1);
    chk("zw_instr", 32'(bus.INSTR),       32'hA5);
    chk("zw_valid", 32'(bus.INSTR_VALID), 32'd1);
    chk("zw_req",   32'(bus.MEM_REQ),     32'd0);
    set_mem(1'b0, 8'h00);
    set_dec(1'b1, 15'h0001);
    step(1);
    chk("acc_pc",  32'(bus.PC),      32'd1);
    chk("acc_req", 32'(bus.MEM_REQ), 32'd1);
    set_dec(1'b0, 15'h7777);

    // Three wait states, then five cycles of decode backpressure
    step(3);
    chk("wait_req",  32'(bus.MEM_REQ),  32'd1);
    chk("wait_addr", 32'(bus.MEM_ADDR), 32'd1);
    set_mem(1'b1, 8'h3C);
    step(1);
    chk("ws_instr", 32'(bus.INSTR), 32'h3C);
    set_mem(1'b1, 8'hEE);
    step(5);
    chk("bp_instr", 32'(bus.INSTR),       32'h3C);
    chk("bp_pc",    32'(bus.PC),          32'd1);
    chk("bp_valid", 32'(bus.INSTR_VALID), 32'd1);
    set_mem(1'b0, 8'h00);

    // Jump to 1234, then sequential step to 1235
    set_dec(1'b1, 15'h1234);
    step(1);
    set_dec(1'b0, 15'h0000);
    chk("jmp_addr", 32'(bus.MEM_ADDR), 32'h1234);
    set_mem(1'b1, 8'hC3);
    step(1);
    set_mem(1'b0, 8'h00);
    set_dec(1'b1, 15'h1235);
    step(1);
    set_dec(1'b0, 15'h0000);
    chk("seq_addr", 32'(bus.MEM_ADDR), 32'h1235);
    chk("seq_req",  32'(bus.MEM_REQ),  32'd1);

    // Timeout with no ack; a late ack must not revive the block
    step(3);
    chk("tmo_pre_err", 32'(bus.FETCH_ERR), 32'd0);
    step(1);
    chk("tmo_err", 32'(bus.FETCH_ERR), 32'd1);
    chk("tmo_req", 32'(bus.MEM_REQ),   32'd0);
    set_mem(1'b1, 8'h99);
    step(2);
    chk("tmo_ack_ignored", 32'(bus.INSTR_VALID), 32'd0);
    chk("tmo_sticky",      32'(bus.FETCH_ERR),   32'd1);
    set_mem(1'b0, 8'h00);

    // Ack on the fourth wait cycle wins over the timeout
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    step(3);
    set_mem(1'b1, 8'h5A);
    step(1);
    set_mem(1'b0, 8'h00);
    chk("late_ack_instr", 32'(bus.INSTR),       32'h5A);
    chk("late_ack_valid", 32'(bus.INSTR_VALID), 32'd1);
    chk("late_ack_err",   32'(bus.FETCH_ERR),   32'd0);

    // HALT at accept parks in idle with the new PC, release restarts fetch
    bus.HALT = 1'b1;
    set_dec(1'b1, 15'h0040);
    step(1);
    set_dec(1'b0, 15'h0000);
    chk("halt_req", 32'(bus.MEM_REQ), 32'd0);
    chk("halt_pc",  32'(bus.PC),      32'h40);
    step(2);
    chk("halt_hold", 32'(bus.MEM_REQ), 32'd0);
    bus.HALT = 1'b0;
    step(1);
    chk("unhalt_req",  32'(bus.MEM_REQ),  32'd1);
    chk("unhalt_addr", 32'(bus.MEM_ADDR), 32'h40);

    // Reset mid-fetch with an ack in the same cycle discards the data
    set_mem(1'b1, 8'hFF);
    rst_n = 1'b0;
    step(1);
    set_mem(1'b0, 8'h00);
    chk("rstack_valid", 32'(bus.INSTR_VALID), 32'd0);
    chk("rstack_instr", 32'(bus.INSTR),       32'd0);
    chk("rstack_pc",    32'(bus.PC),          32'd0);
    rst_n = 1'b1;
    step(1);
    chk("rstack_refetch", 32'(bus.MEM_REQ), 32'd1);
    set_mem(1'b1, 8'h11);
    step(1);
    set_mem(1'b0, 8'h00);
    chk("rstack_instr2", 32'(bus.INSTR), 32'h11);
    set_dec(1'b1, 15'h0001);
    step(1);
    set_dec(1'b0, 15'h0000);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
